serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder built around the existing single-bit `full_adder`. It accepts two operands through a valid/ready handshake and feeds them LSB-first into one `full_adder` instance, one bit per cycle, with the carry held in a register between bits. The WIDTH-bit sum and final carry are returned through a second valid/ready handshake. It is the sequential stage that drives a `full_adder` across a full word.

## Interface
- `WIDTH`, default 8: operand/sum width in bits; legal range ≥ 2.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands present.
- `in_ready` out 1: block can accept operands.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `c_in` in 1: carry-in for bit 0.
- `sub` in 1: subtract request; the port exists only with `SERIAL_ADDER_SUB_EN`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `sum` out WIDTH: result.
- `c_out` out 1: carry out of the MSB.

## Operation
- States:
  - IDLE: `in_ready`=1.
    - On `in_valid`: capture `a`, `b` into shift registers, load the carry register with `c_in`, clear the bit counter, go to RUN.
  - RUN: each cycle, drive `full_adder` with `a_sr[0]`, `b_sr[0]`, `carry`.
    - Shift the sum bit into `sum_sr` at the MSB.
    - Shift `a_sr` and `b_sr` right by 1.
    - Load `carry` with the `full_adder` carry.
    - Increment the counter.
    - After WIDTH bits, go to DONE.
  - DONE: `out_valid`=1.
    - On `out_ready`, go to IDLE.
- `in_ready` = (state==IDLE). `out_valid` = (state==DONE).
- `sum` = `sum_sr` and `c_out` = `carry`, both driven directly from the registers.
  - Meaningful only while `out_valid`=1.
  - Hold the last result through IDLE until the next RUN starts shifting.
- Arithmetic: {`c_out`,`sum`} = `a` + `b` + `c_in`, computed modulo 2^(WIDTH+1).
- Counter width is $clog2(WIDTH+1).
- `in_valid` is ignored outside IDLE: no queuing, no error.
- `out_ready` is ignored outside DONE.
- Reset, asynchronous and effective at any state including mid-RUN:
  - State goes to IDLE.
  - `a_sr`, `b_sr`, `sum_sr`, `carry`, and the counter clear to 0.
  - Outputs during and after reset: `out_valid`=0, `sum`=0, `c_out`=0, `in_ready`=1.
  - The in-flight operation is discarded.

## Timing
- Acceptance edge E: `in_valid` & `in_ready` both high at the rising edge of `clk`.
- RUN spans edges E+1 … E+WIDTH; bit i is processed at edge E+1+i.
- `out_valid` rises after edge E+WIDTH, i.e. latency is WIDTH cycles from acceptance.
- DONE holds for at least one cycle. It exits at the first edge with `out_ready`=1, with no combinational `out_ready`→`in_ready` path.
- Minimum period between acceptances is WIDTH+2 cycles: WIDTH in RUN, 1 in DONE, 1 in IDLE.
- Under backpressure, `out_valid`, `sum`, and `c_out` stay stable while `out_ready`=0.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - The `sub` port exists.
  - When `sub`=1 at acceptance, `b_sr` loads ~`b` and `carry` loads 1; `c_in` is ignored.
  - Result: `sum` = `a` − `b` mod 2^WIDTH, with `c_out`=1 meaning no borrow.
  - When `sub`=0, behaviour is identical to the undefined case.
- `SERIAL_ADDER_SUB_EN` undefined: no `sub` port; add only.

## Structure
- Package `serial_adder_pkg`:
  - typedef enum logic [1:0] `state_t` {IDLE=0, RUN=1, DONE=2}.
  - Constant `DEFAULT_WIDTH`=8.
- Sub-module: the existing `full_adder`, instantiated once. No other hierarchy.

## Test plan
All scenarios use WIDTH=8.
- Basic add: `a`=0x3C, `b`=0x42, `c_in`=0 → `out_valid` exactly 8 cycles after acceptance, `sum`=0x7E, `c_out`=0.
- Full carry chain: `a`=0xFF, `b`=0x01, `c_in`=0 → `sum`=0x00, `c_out`=1. Also `a`=0xFF, `b`=0xFF, `c_in`=1 → `sum`=0xFF, `c_out`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE.
  - `out_valid`=1, `sum`, and `c_out` remain stable; `in_ready`=0.
  - A competing `in_valid` pulse with `a`=0x11 is ignored.
  - Release `out_ready` → IDLE next edge.
- Back-to-back: assert `in_valid` continuously with new operands and hold `out_ready`=1 → acceptances are spaced exactly 10 cycles apart, and each result is correct.
- Reset mid-RUN: drop `rst_n` after 3 RUN cycles.
  - Immediately `out_valid`=0, `sum`=0, `c_out`=0, `in_ready`=1.
  - After release, a fresh 0x01+0x01 gives 0x02.
- With `SERIAL_ADDER_SUB_EN`: `sub`=1, `a`=0x05, `b`=0x07 → `sum`=0xFE, `c_out`=0. `sub`=1, `a`=0x07, `b`=0x05 → `sum`=0x02, `c_out`=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Operand and result handshakes of the bit-serial adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output in_valid, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, c_out
    );

endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder used as the arithmetic core of serial_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder walks the operands LSB-first.
// Optional SERIAL_ADDER_SUB_EN adds a sub input for two's-complement subtract.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // Subtraction is a + ~b + 1, so only the operand and carry loads change.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub ? 1'b1 : bus.c_in;
`else
    assign b_load     = bus.b;
    assign carry_load = bus.c_in;
`endif

    full_adder u_full_adder (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .c_in (carry),
        .sum  (fa_sum),
        .c_out(fa_carry)
    );

    assign accept   = (state == IDLE) && bus.in_valid;
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.in_valid) next_state = RUN;
            RUN:  if (last_bit) next_state = DONE;
            DONE: if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // sum_sr fills from the MSB so bit 0 lands in place after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
        end else if (accept) begin
            a_sr    <= bus.a;
            b_sr    <= b_load;
            carry   <= carry_load;
            bit_cnt <= '0;
        end else if (state == RUN) begin
            a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
            sum_sr  <= {fa_sum, sum_sr[WIDTH-1:1]};
            carry   <= fa_carry;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_sr;
    assign bus.c_out     = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    logic cur_sub;
    int   n_checks;
    int   n_pass;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

`ifdef SERIAL_ADDER_SUB_EN
    assign bus.sub = cur_sub;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic, or a - b with c_out meaning "no borrow".
    function automatic logic [8:0] ref_result(input logic [7:0] av, input logic [7:0] bv,
                                              input logic cv, input logic sb);
        int unsigned total;
        logic [7:0]  diff;
        if (sb) begin
            diff = av - bv;
            return {(av >= bv), diff};
        end
        total = 32'(av) + 32'(bv) + 32'(cv);
        return total[8:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic apply_stimulus(input logic [7:0] av, input logic [7:0] bv,
                                  input logic cv, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 40) begin
            step();
            guard++;
        end
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.a        = av;
        bus.b        = bv;
        bus.c_in     = cv;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic check_output(input string tag, input logic [7:0] av, input logic [7:0] bv,
                                input logic cv, input logic sb);
        logic [8:0] exp;
        exp = ref_result(av, bv, cv, sb);
        check({tag, "_sum"}, 32'(bus.sum), 32'(exp[7:0]));
        check({tag, "_c_out"}, 32'(bus.c_out), 32'(exp[8]));
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("out_valid_after_consume", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_consume", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_one(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic cv, input logic sb);
        int lat;
        cur_sub = sb;
        apply_stimulus(av, bv, cv, lat);
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check_output(tag, av, bv, cv, sb);
        consume();
        cur_sub = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb, held_sum;
        logic       rc, rs, held_c;
        logic [8:0] exp;
        logic [8:0] exp_q[$];
        int         lat, cyc, last_acc, accepted, popped;
        bit         just_accepted;

        n_checks      = 0;
        n_pass        = 0;
        cur_sub       = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;

        #2;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_sum", 32'(bus.sum), 32'd0);
        check("reset_c_out", 32'(bus.c_out), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] basic add and carry chains");
        cur_sub = 1'b0;
        apply_stimulus(8'h3C, 8'h42, 1'b0, lat);
        check("basic_latency", 32'(lat), 32'd8);
        check("basic_sum", 32'(bus.sum), 32'h7E);
        check("basic_c_out", 32'(bus.c_out), 32'd0);
        consume();
        check("idle_hold_sum", 32'(bus.sum), 32'h7E);
        run_one("chain_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_one("chain_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0);

        $display("[TB] backpressure");
        apply_stimulus(8'hA5, 8'h5A, 1'b1, lat);
        check("bp_latency", 32'(lat), 32'd8);
        check_output("bp", 8'hA5, 8'h5A, 1'b1, 1'b0);
        held_sum = bus.sum;
        held_c   = bus.c_out;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.a        = 8'h11;
                bus.b        = 8'h00;
                bus.in_valid = 1'b1;
            end
            step();
            bus.in_valid = 1'b0;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_sum_stable", 32'(bus.sum), 32'(held_sum));
            check("bp_c_out_stable", 32'(bus.c_out), 32'(held_c));
        end
        consume();
        check("bp_pulse_ignored_sum", 32'(bus.sum), 32'(held_sum));

        $display("[TB] back-to-back");
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom_range(0, 1));
        bus.a         = ra;
        bus.b         = rb;
        bus.c_in      = rc;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cyc           = 0;
        last_acc      = -1;
        accepted      = 0;
        popped        = 0;
        while ((accepted < 4 || popped < 4) && cyc < 100) begin
            just_accepted = 1'b0;
            if (bus.out_valid && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("b2b_sum", 32'(bus.sum), 32'(exp[7:0]));
                check("b2b_c_out", 32'(bus.c_out), 32'(exp[8]));
                popped++;
            end
            if (bus.in_ready && bus.in_valid) begin
                if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd10);
                last_acc = cyc;
                exp_q.push_back(ref_result(ra, rb, rc, 1'b0));
                accepted++;
                just_accepted = 1'b1;
            end
            step();
            cyc++;
            if (just_accepted) begin
                if (accepted == 4) begin
                    bus.in_valid = 1'b0;
                end else begin
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    bus.a    = ra;
                    bus.b    = rb;
                    bus.c_in = rc;
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_accepted", 32'(accepted), 32'd4);
        check("b2b_popped", 32'(popped), 32'd4);
        step();

        $display("[TB] reset mid-run");
        bus.a        = 8'h3C;
        bus.b        = 8'h42;
        bus.c_in     = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rst_run_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_run_sum", 32'(bus.sum), 32'd0);
        check("rst_run_c_out", 32'(bus.c_out), 32'd0);
        check("rst_run_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;
        step();
        run_one("post_reset", 8'h01, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        $display("[TB] subtract");
        run_one("sub_5_7", 8'h05, 8'h07, 1'b0, 1'b1);
        run_one("sub_7_5", 8'h07, 8'h05, 1'b0, 1'b1);
`endif

        $display("[TB] random operands");
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_one("random", ra, rb, rc, rs);
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
